// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the BCD digit width and the add-3 adjust rule.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_seq_state_t;

    localparam int BCD_DIGIT_W = 4;

    // Double-dabble adjust: a digit of 5 or more becomes 8 or more after +3,
    // so the next left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_add3(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Combinational 4-bit add-3 adjust cell for one BCD digit.
// No carry in or out: adjusted digits never exceed 12, so 4 bits suffice.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = bcd_add3(digit_i);

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts BIN_W-bit words on a valid/ready input, produces DIGITS packed BCD
// digits on a valid/ready output after BIN_W shift cycles.
// Optional feature macro: BCD_SEQ_LEADZERO_EN adds the out_blank port, a
// per-digit leading-zero blanking mask registered together with out_bcd.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          busy
`ifdef BCD_SEQ_LEADZERO_EN
    ,
    output logic [DIGITS-1:0]             out_blank
`endif
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    // Number of values representable by DIGITS decimal digits.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned DEC_RANGE = pow10(DIGITS);
    localparam longint unsigned BIN_MAX   = (64'd1 << BIN_W) - 64'd1;

    // Reject configurations that could overflow the BCD field.
    generate
        if (BIN_W < 4 || BIN_W > 16) begin : g_bad_bin_w
            $error("bcd_seq_converter: BIN_W=%0d outside 4..16", BIN_W);
        end
        if (DEC_RANGE <= BIN_MAX) begin : g_bad_digits
            $error("bcd_seq_converter: DIGITS=%0d too few for BIN_W=%0d", DIGITS, BIN_W);
        end
    endgenerate

    bcd_seq_state_t       state_q;
    logic [WORK_W-1:0]    work_q;
    logic [WORK_W-1:0]    work_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_d;
    logic [BCD_W-1:0]     out_bcd_q;
    logic                 out_valid_q;
    logic                 in_ready_q;
    logic                 busy_q;

    // One add-3 cell per BCD digit of the work register.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_add3_cell u_cell (
                .digit_i (work_q[BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Adjusted BCD field and untouched binary field, shifted left by one.
    assign work_d = {bcd_adj[BCD_W-2:0], work_q[BIN_W-1:0], 1'b0};
    assign bcd_d  = work_d[WORK_W-1 -: BCD_W];

`ifdef BCD_SEQ_LEADZERO_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;
    logic              hi_zero;

    // Blank a digit when it and every higher digit are zero; units never blank.
    always_comb begin
        blank_d = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero    = hi_zero && (bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_d[i] = hi_zero;
        end
        blank_d[0] = 1'b0;
    end
`endif

    // Control FSM with work register, shift counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef BCD_SEQ_LEADZERO_EN
            blank_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= {{BCD_W{1'b0}}, in_bin};
                        cnt_q      <= CNT_W'(BIN_W);
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_bcd_q   <= bcd_d;
                        out_valid_q <= 1'b1;
`ifdef BCD_SEQ_LEADZERO_EN
                        blank_q     <= blank_d;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign busy      = busy_q;
`ifdef BCD_SEQ_LEADZERO_EN
    assign out_blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed testbench for bcd_seq_converter: an 8-bit/3-digit instance and a
// 4-bit/2-digit instance share clock and reset. Leading-zero checks are
// compiled only when BCD_SEQ_LEADZERO_EN is defined.
module tb_bcd_seq_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid_a = 1'b0;
    logic        in_ready_a;
    logic [7:0]  in_bin_a = '0;
    logic        out_valid_a;
    logic        out_ready_a = 1'b0;
    logic [11:0] out_bcd_a;
    logic        busy_a;

    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [3:0]  in_bin_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b0;
    logic [7:0]  out_bcd_b;
    logic        busy_b;

`ifdef BCD_SEQ_LEADZERO_EN
    logic [2:0]  out_blank_a;
    logic [1:0]  out_blank_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_bin    (in_bin_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_bcd   (out_bcd_a),
        .busy      (busy_a)
`ifdef BCD_SEQ_LEADZERO_EN
        ,
        .out_blank (out_blank_a)
`endif
    );

    bcd_seq_converter #(.BIN_W(4), .DIGITS(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_bin    (in_bin_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_bcd   (out_bcd_b),
        .busy      (busy_b)
`ifdef BCD_SEQ_LEADZERO_EN
        ,
        .out_blank (out_blank_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Convert one value on the 8-bit instance, optionally holding out_ready low
    // for 'hold' DONE cycles while poking in_valid with a different operand.
    task automatic run_a(input logic [7:0] val, input logic [11:0] exp, input int hold);
        int lat;
        check("a_idle_ready", in_ready_a, 1);
        in_bin_a   = val;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        check("a_accept_busy", busy_a, 1);
        check("a_accept_in_ready", in_ready_a, 0);
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("a_latency", lat, 8);
        check("a_bcd", out_bcd_a, exp);
        for (int k = 0; k < hold; k++) begin
            in_bin_a   = ~val;
            in_valid_a = 1'b1;
            @(posedge clk); #1;
            check("a_hold_valid", out_valid_a, 1);
            check("a_hold_bcd", out_bcd_a, exp);
            check("a_hold_in_ready", in_ready_a, 0);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        check("a_post_valid", out_valid_a, 0);
        check("a_post_in_ready", in_ready_a, 1);
        check("a_post_busy", busy_a, 0);
        check("a_post_bcd_held", out_bcd_a, exp);
        $display("A: in=%0d bcd=%03h latency=%0d hold=%0d", val, out_bcd_a, lat, hold);
    endtask

    // Convert one value on the 4-bit instance.
    task automatic run_b(input logic [3:0] val, input logic [7:0] exp);
        int lat;
        in_bin_b   = val;
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        lat = 0;
        while (!out_valid_b && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b_latency", lat, 4);
        check("b_bcd", out_bcd_b, exp);
        out_ready_b = 1'b1;
        @(posedge clk); #1;
        out_ready_b = 1'b0;
        check("b_post_in_ready", in_ready_b, 1);
        $display("B: in=%0d bcd=%02h latency=%0d", val, out_bcd_b, lat);
    endtask

    initial begin
        // Reset held low for three cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_bcd", out_bcd_a, 12'h000);
        check("rst_busy", busy_a, 0);
        check("rst_in_ready", in_ready_a, 1);
`ifdef BCD_SEQ_LEADZERO_EN
        check("rst_blank", out_blank_a, 3'b000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("RESET: out_valid=%0b out_bcd=%03h busy=%0b in_ready=%0b",
                 out_valid_a, out_bcd_a, busy_a, in_ready_a);

        run_a(8'd0, 12'h000, 0);
`ifdef BCD_SEQ_LEADZERO_EN
        check("blank_0", out_blank_a, 3'b110);
`endif
        run_a(8'd255, 12'h255, 0);
`ifdef BCD_SEQ_LEADZERO_EN
        check("blank_255", out_blank_a, 3'b000);
`endif
        run_a(8'd128, 12'h128, 5);
        run_a(8'd7, 12'h007, 0);
`ifdef BCD_SEQ_LEADZERO_EN
        check("blank_7", out_blank_a, 3'b110);
`endif
        run_a(8'd64, 12'h064, 0);

        // Abort a conversion with reset in its fourth SHIFT cycle.
        in_bin_a   = 8'd200;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid_a, 0);
        check("abort_out_bcd", out_bcd_a, 12'h000);
        check("abort_busy", busy_a, 0);
        check("abort_in_ready", in_ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_result", out_valid_a, 0);
        $display("ABORT: out_valid=%0b out_bcd=%03h", out_valid_a, out_bcd_a);
        run_a(8'd99, 12'h099, 0);

        // Small instance: full sweep plus the named boundary values.
        for (int v = 0; v < 16; v++) begin
            run_b(4'(v), {4'(v / 10), 4'(v % 10)});
        end
        run_b(4'd10, 8'h10);
        run_b(4'd15, 8'h15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
